// File: rtl/alu_rsv_issue.sv
// Data-capture reservation station in front of a single ALU: holds renamed uops until their
// operands arrive via PRF writeback snooping, then issues one per cycle. Optional: RSV_AGE_SELECT_EN.
module alu_rsv_issue #(
  parameter int unsigned RSV_DEPTH      = 4,
  parameter int unsigned PRF_CODE_WIDTH = 6,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ROB_ID_WIDTH   = 8,
  parameter int unsigned IMM_WIDTH      = 32,
  parameter int unsigned DECINFO_WIDTH  = 64,
  parameter int unsigned EXCP_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_csr_trap_flush,
  input  logic                      i_exu_mis_flush,
  input  logic [ROB_ID_WIDTH-1:0]   i_exu_mis_rob_id,
  input  logic                      i_exu_ls_flush,
  input  logic [ROB_ID_WIDTH-1:0]   i_exu_ls_rob_id,
  input  logic                      i_disp_vld,
  output logic                      o_disp_rdy,
  input  logic                      i_disp_src1_vld,
  input  logic [PRF_CODE_WIDTH-1:0] i_disp_src1_code,
  input  logic                      i_disp_src1_rdy,
  input  logic [DATA_WIDTH-1:0]     i_disp_src1_dat,
  input  logic                      i_disp_src2_vld,
  input  logic [PRF_CODE_WIDTH-1:0] i_disp_src2_code,
  input  logic                      i_disp_src2_rdy,
  input  logic [DATA_WIDTH-1:0]     i_disp_src2_dat,
  input  logic                      i_disp_dst_vld,
  input  logic [PRF_CODE_WIDTH-1:0] i_disp_dst_code,
  input  logic [IMM_WIDTH-1:0]      i_disp_imm,
  input  logic [ROB_ID_WIDTH-1:0]   i_disp_rob_id,
  input  logic [DECINFO_WIDTH-1:0]  i_disp_decinfo_bus,
  input  logic [EXCP_WIDTH-1:0]     i_disp_excp_code,
  input  logic                      i_wb_vld,
  input  logic [PRF_CODE_WIDTH-1:0] i_wb_prf_code,
  input  logic [DATA_WIDTH-1:0]     i_wb_dat,
  input  logic                      i_exu_rsv_idle,
  output logic                      o_rsv_exu_vld,
  output logic                      o_rsv_exu_src1_vld,
  output logic [DATA_WIDTH-1:0]     o_rsv_exu_src1_dat,
  output logic                      o_rsv_exu_src2_vld,
  output logic [DATA_WIDTH-1:0]     o_rsv_exu_src2_dat,
  output logic                      o_rsv_exu_dst_vld,
  output logic [PRF_CODE_WIDTH-1:0] o_rsv_exu_dst_code,
  output logic [IMM_WIDTH-1:0]      o_rsv_exu_imm,
  output logic [ROB_ID_WIDTH-1:0]   o_rsv_exu_rob_id,
  output logic [DECINFO_WIDTH-1:0]  o_rsv_exu_decinfo_bus,
  output logic [EXCP_WIDTH-1:0]     o_rsv_exu_excp_code,
  output logic                      o_rsv_empty
);

  localparam int unsigned IdxW = (RSV_DEPTH > 1) ? $clog2(RSV_DEPTH) : 1;
  typedef logic [IdxW-1:0] idx_t;

  // Entry state: valid and ready flags are packed vectors, the rest are per-entry arrays.
  logic [RSV_DEPTH-1:0]      vld_q, vld_d;
  logic [RSV_DEPTH-1:0]      src1_rdy_q, src1_rdy_d;
  logic [RSV_DEPTH-1:0]      src2_rdy_q, src2_rdy_d;
  logic [DATA_WIDTH-1:0]     src1_dat_q [RSV_DEPTH];
  logic [DATA_WIDTH-1:0]     src1_dat_d [RSV_DEPTH];
  logic [DATA_WIDTH-1:0]     src2_dat_q [RSV_DEPTH];
  logic [DATA_WIDTH-1:0]     src2_dat_d [RSV_DEPTH];
  logic [RSV_DEPTH-1:0]      src1_vld_q;
  logic [RSV_DEPTH-1:0]      src2_vld_q;
  logic [PRF_CODE_WIDTH-1:0] src1_code_q [RSV_DEPTH];
  logic [PRF_CODE_WIDTH-1:0] src2_code_q [RSV_DEPTH];
  logic [RSV_DEPTH-1:0]      dst_vld_q;
  logic [PRF_CODE_WIDTH-1:0] dst_code_q [RSV_DEPTH];
  logic [IMM_WIDTH-1:0]      imm_q [RSV_DEPTH];
  logic [ROB_ID_WIDTH-1:0]   rob_id_q [RSV_DEPTH];
  logic [DECINFO_WIDTH-1:0]  decinfo_q [RSV_DEPTH];
  logic [EXCP_WIDTH-1:0]     excp_q [RSV_DEPTH];

  logic                      flush_any;
  logic                      flush_rob;
  logic [ROB_ID_WIDTH-1:0]   flush_id;
  logic                      disp_fire;
  logic                      issue_fire;
  idx_t                      alloc_idx;
  idx_t                      issue_idx;
  logic [RSV_DEPTH-1:0]      issue_req;
  logic                      src1_bypass, src2_bypass;
  logic                      src1_rdy_new, src2_rdy_new;
  logic [DATA_WIDTH-1:0]     src1_dat_new, src2_dat_new;

  // a is older than b; the MSB is the ROB wrap bit.
  function automatic logic is_older(input logic [ROB_ID_WIDTH-1:0] a,
                                    input logic [ROB_ID_WIDTH-1:0] b);
    if (a[ROB_ID_WIDTH-1] == b[ROB_ID_WIDTH-1]) begin
      return a[ROB_ID_WIDTH-2:0] < b[ROB_ID_WIDTH-2:0];
    end else begin
      return a[ROB_ID_WIDTH-2:0] >= b[ROB_ID_WIDTH-2:0];
    end
  endfunction

  assign flush_rob = i_exu_mis_flush | i_exu_ls_flush;
  assign flush_any = i_csr_trap_flush | flush_rob;

  always_comb begin
    flush_id = i_exu_mis_rob_id;
    if (i_exu_mis_flush && i_exu_ls_flush) begin
      if (is_older(i_exu_ls_rob_id, i_exu_mis_rob_id)) begin
        flush_id = i_exu_ls_rob_id;
      end
    end else if (i_exu_ls_flush) begin
      flush_id = i_exu_ls_rob_id;
    end
  end

  // Lowest-index free entry.
  always_comb begin
    alloc_idx = '0;
    for (int i = int'(RSV_DEPTH) - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        alloc_idx = idx_t'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(RSV_DEPTH); i++) begin
      issue_req[i] = vld_q[i] & ((src1_rdy_q[i] & src2_rdy_q[i]) | (|excp_q[i]));
    end
  end

`ifdef RSV_AGE_SELECT_EN
  logic sel_found;

  always_comb begin
    issue_idx = '0;
    sel_found = 1'b0;
    for (int i = 0; i < int'(RSV_DEPTH); i++) begin
      if (issue_req[i] && (!sel_found || is_older(rob_id_q[i], rob_id_q[issue_idx]))) begin
        issue_idx = idx_t'(i);
        sel_found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    issue_idx = '0;
    for (int i = int'(RSV_DEPTH) - 1; i >= 0; i--) begin
      if (issue_req[i]) begin
        issue_idx = idx_t'(i);
      end
    end
  end
`endif

  assign o_disp_rdy  = ~&vld_q;
  assign o_rsv_empty = ~|vld_q;
  assign disp_fire   = i_disp_vld & o_disp_rdy & ~flush_any;
  assign issue_fire  = i_exu_rsv_idle & (|issue_req) & ~flush_any;

  // issue_idx falls back to entry 0 when nothing requests.
  assign o_rsv_exu_vld         = issue_fire;
  assign o_rsv_exu_src1_vld    = src1_vld_q[issue_idx];
  assign o_rsv_exu_src1_dat    = src1_dat_q[issue_idx];
  assign o_rsv_exu_src2_vld    = src2_vld_q[issue_idx];
  assign o_rsv_exu_src2_dat    = src2_dat_q[issue_idx];
  assign o_rsv_exu_dst_vld     = dst_vld_q[issue_idx];
  assign o_rsv_exu_dst_code    = dst_code_q[issue_idx];
  assign o_rsv_exu_imm         = imm_q[issue_idx];
  assign o_rsv_exu_rob_id      = rob_id_q[issue_idx];
  assign o_rsv_exu_decinfo_bus = decinfo_q[issue_idx];
  assign o_rsv_exu_excp_code   = excp_q[issue_idx];

  // A not-ready dispatching source can pick up a same-cycle writeback directly.
  assign src1_bypass  = i_wb_vld & (i_wb_prf_code == i_disp_src1_code);
  assign src2_bypass  = i_wb_vld & (i_wb_prf_code == i_disp_src2_code);
  assign src1_rdy_new = ~i_disp_src1_vld | i_disp_src1_rdy | src1_bypass;
  assign src2_rdy_new = ~i_disp_src2_vld | i_disp_src2_rdy | src2_bypass;
  assign src1_dat_new = (i_disp_src1_vld & ~i_disp_src1_rdy & src1_bypass) ? i_wb_dat
                                                                           : i_disp_src1_dat;
  assign src2_dat_new = (i_disp_src2_vld & ~i_disp_src2_rdy & src2_bypass) ? i_wb_dat
                                                                           : i_disp_src2_dat;

  always_comb begin
    vld_d      = vld_q;
    src1_rdy_d = src1_rdy_q;
    src2_rdy_d = src2_rdy_q;
    src1_dat_d = src1_dat_q;
    src2_dat_d = src2_dat_q;

    for (int i = 0; i < int'(RSV_DEPTH); i++) begin
      if (vld_q[i] && i_wb_vld) begin
        if (!src1_rdy_q[i] && (src1_code_q[i] == i_wb_prf_code)) begin
          src1_rdy_d[i] = 1'b1;
          src1_dat_d[i] = i_wb_dat;
        end
        if (!src2_rdy_q[i] && (src2_code_q[i] == i_wb_prf_code)) begin
          src2_rdy_d[i] = 1'b1;
          src2_dat_d[i] = i_wb_dat;
        end
      end
    end

    if (issue_fire) begin
      vld_d[issue_idx] = 1'b0;
    end

    if (disp_fire) begin
      vld_d[alloc_idx]      = 1'b1;
      src1_rdy_d[alloc_idx] = src1_rdy_new;
      src2_rdy_d[alloc_idx] = src2_rdy_new;
      src1_dat_d[alloc_idx] = src1_dat_new;
      src2_dat_d[alloc_idx] = src2_dat_new;
    end

    // Flush cycles never dispatch or issue, so killing from vld_q is sufficient.
    if (i_csr_trap_flush) begin
      vld_d = '0;
    end else if (flush_rob) begin
      for (int i = 0; i < int'(RSV_DEPTH); i++) begin
        if (is_older(flush_id, rob_id_q[i])) begin
          vld_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    src1_rdy_q <= src1_rdy_d;
    src2_rdy_q <= src2_rdy_d;
    src1_dat_q <= src1_dat_d;
    src2_dat_q <= src2_dat_d;
    if (disp_fire) begin
      src1_vld_q[alloc_idx]  <= i_disp_src1_vld;
      src2_vld_q[alloc_idx]  <= i_disp_src2_vld;
      src1_code_q[alloc_idx] <= i_disp_src1_code;
      src2_code_q[alloc_idx] <= i_disp_src2_code;
      dst_vld_q[alloc_idx]   <= i_disp_dst_vld;
      dst_code_q[alloc_idx]  <= i_disp_dst_code;
      imm_q[alloc_idx]       <= i_disp_imm;
      rob_id_q[alloc_idx]    <= i_disp_rob_id;
      decinfo_q[alloc_idx]   <= i_disp_decinfo_bus;
      excp_q[alloc_idx]      <= i_disp_excp_code;
    end
  end

endmodule
